// File: rtl/id_pkg.sv
// Shared decode-stage definitions: opcodes, control enums, EXE bundle layout.
// The EXE bundle is {pc, src1, src2, imm, rd, alu_op, br_type, rf_we, mem_re, mem_we, illegal}.
package id_pkg;

  localparam logic [31:0] ID_RESET_PC = 32'h1C00_0000;
  localparam int          ID_OUT_W    = 144;

  // Bit offsets of each out_bus field (LSB position).
  localparam int OFF_ILLEGAL = 0;
  localparam int OFF_MEM_WE  = 1;
  localparam int OFF_MEM_RE  = 2;
  localparam int OFF_RF_WE   = 3;
  localparam int OFF_BR      = 4;
  localparam int OFF_ALU     = 7;
  localparam int OFF_RD      = 11;
  localparam int OFF_IMM     = 16;
  localparam int OFF_SRC2    = 48;
  localparam int OFF_SRC1    = 80;
  localparam int OFF_PC      = 112;

  localparam logic [16:0] OP17_ADD   = 17'h00020;
  localparam logic [16:0] OP17_SUB   = 17'h00022;
  localparam logic [16:0] OP17_AND   = 17'h00029;
  localparam logic [16:0] OP17_OR    = 17'h0002A;
  localparam logic [16:0] OP17_XOR   = 17'h0002B;
  localparam logic [9:0]  OP10_ADDI  = 10'h00A;
  localparam logic [9:0]  OP10_LD    = 10'h0A2;
  localparam logic [9:0]  OP10_ST    = 10'h0A6;
  localparam logic [6:0]  OP7_LU12I  = 7'h0A;
  localparam logic [5:0]  OP6_JIRL   = 6'h13;
  localparam logic [5:0]  OP6_B      = 6'h14;
  localparam logic [5:0]  OP6_BL     = 6'h15;
  localparam logic [5:0]  OP6_BEQ    = 6'h16;
  localparam logic [5:0]  OP6_BNE    = 6'h17;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_LUI = 4'd5
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_B    = 3'd1,
    BR_BL   = 3'd2,
    BR_JIRL = 3'd3,
    BR_BEQ  = 3'd4,
    BR_BNE  = 3'd5
  } br_type_e;

  typedef struct packed {
    logic signed [31:0] imm;
    logic [4:0]         rd;
    alu_op_e            alu_op;
    br_type_e           br_type;
    logic               rf_we;
    logic               mem_re;
    logic               mem_we;
    logic               illegal;
    logic [4:0]         raddr1;
    logic [4:0]         raddr2;
  } dec_t;

  function automatic logic signed [31:0] sext_si12(input logic signed [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

  // Branch offsets are word offsets: sign-extend then scale to bytes.
  function automatic logic signed [31:0] sext_offs16(input logic signed [15:0] v);
    return {{14{v[15]}}, v, 2'b00};
  endfunction

  function automatic logic signed [31:0] sext_offs26(input logic signed [25:0] v);
    return {{4{v[25]}}, v, 2'b00};
  endfunction

endpackage

// File: rtl/id_decoder.sv
// Purely combinational LA32R-subset decoder: instruction word to control,
// immediate and register-index fields. Unrecognised encodings come out as illegal.
module id_decoder
  import id_pkg::*;
(
  input  logic [31:0] inst,
  output dec_t        dec
);

  logic [4:0] rd;
  logic [4:0] rj;
  logic [4:0] rk;

  assign rd = inst[4:0];
  assign rj = inst[9:5];
  assign rk = inst[14:10];

  always_comb begin
    dec         = '0;
    dec.rd      = rd;
    dec.raddr1  = rj;
    dec.raddr2  = rk;
    dec.alu_op  = ALU_ADD;
    dec.br_type = BR_NONE;

    if (inst[31:15] inside {OP17_ADD, OP17_SUB, OP17_AND, OP17_OR, OP17_XOR}) begin
      dec.rf_we = 1'b1;
      case (inst[31:15])
        OP17_SUB: dec.alu_op = ALU_SUB;
        OP17_AND: dec.alu_op = ALU_AND;
        OP17_OR:  dec.alu_op = ALU_OR;
        OP17_XOR: dec.alu_op = ALU_XOR;
        default:  dec.alu_op = ALU_ADD;
      endcase
    end else if (inst[31:22] == OP10_ADDI) begin
      dec.imm   = sext_si12(inst[21:10]);
      dec.rf_we = 1'b1;
    end else if (inst[31:22] == OP10_LD) begin
      dec.imm    = sext_si12(inst[21:10]);
      dec.rf_we  = 1'b1;
      dec.mem_re = 1'b1;
    end else if (inst[31:22] == OP10_ST) begin
      // Store data comes from rd, so the second read port is steered there.
      dec.imm    = sext_si12(inst[21:10]);
      dec.mem_we = 1'b1;
      dec.raddr2 = rd;
    end else if (inst[31:25] == OP7_LU12I) begin
      // Reading r0 makes src1 zero so EXE can treat LUI as a plain pass of imm.
      dec.imm    = {inst[24:5], 12'h000};
      dec.alu_op = ALU_LUI;
      dec.rf_we  = 1'b1;
      dec.raddr1 = 5'd0;
    end else if (inst[31:26] == OP6_JIRL) begin
      dec.imm     = sext_offs16(inst[25:10]);
      dec.br_type = BR_JIRL;
      dec.rf_we   = 1'b1;
    end else if (inst[31:26] == OP6_B) begin
      dec.imm     = sext_offs26({inst[9:0], inst[25:10]});
      dec.br_type = BR_B;
    end else if (inst[31:26] == OP6_BL) begin
      dec.imm     = sext_offs26({inst[9:0], inst[25:10]});
      dec.br_type = BR_BL;
      dec.rd      = 5'd1;
      dec.rf_we   = 1'b1;
    end else if (inst[31:26] == OP6_BEQ || inst[31:26] == OP6_BNE) begin
      dec.imm     = sext_offs16(inst[25:10]);
      dec.br_type = (inst[31:26] == OP6_BEQ) ? BR_BEQ : BR_BNE;
      dec.raddr2  = rd;
    end else begin
      dec.illegal = 1'b1;
    end

    if (dec.rd == 5'd0) begin
      dec.rf_we = 1'b0;
    end
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: accepts {pc,inst} from fetch, decodes, and holds one registered
// bundle for EXE with register operands read live from the held indices.
module id_stage
  import id_pkg::*;
#(
  parameter logic [31:0] RESET_PC = ID_RESET_PC,
  parameter int          OUT_W    = ID_OUT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_bus,
  input  logic             flush,
  output logic [4:0]       rf_raddr1,
  output logic [4:0]       rf_raddr2,
  input  logic [31:0]      rf_rdata1,
  input  logic [31:0]      rf_rdata2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_bus
);

  dec_t        dec_p0;
  dec_t        dec_p1;
  logic [31:0] pc_p1;
  logic        vld_p1;
  logic        in_fire;
  logic        out_fire;

  id_decoder u_decoder (
    .inst (in_bus[31:0]),
    .dec  (dec_p0)
  );

  assign in_ready = ~vld_p1 | out_ready;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = vld_p1 & out_ready;

  // p0 -> p1: flush outranks a same-cycle accept so a redirected inst never reaches EXE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      pc_p1  <= RESET_PC;
      dec_p1 <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (in_fire) begin
      vld_p1 <= 1'b1;
      pc_p1  <= in_bus[63:32];
      dec_p1 <= dec_p0;
    end else if (out_fire) begin
      vld_p1 <= 1'b0;
    end
  end

  // p1 -> EXE: operands stay combinational so write-backs during a stall are observed.
  assign rf_raddr1 = dec_p1.raddr1;
  assign rf_raddr2 = dec_p1.raddr2;
  assign out_valid = vld_p1;
  assign out_bus   = {pc_p1, rf_rdata1, rf_rdata2, dec_p1.imm, dec_p1.rd,
                      dec_p1.alu_op, dec_p1.br_type, dec_p1.rf_we,
                      dec_p1.mem_re, dec_p1.mem_we, dec_p1.illegal};

endmodule

// File: tb/tb_id_stage.sv
// Directed and randomized check of id_stage against a mnemonic-level reference
// model of the decode rules and the one-entry valid/ready register.
module tb_id_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_bus;
  logic         flush;
  logic [4:0]   rf_raddr1;
  logic [4:0]   rf_raddr2;
  logic [31:0]  rf_rdata1;
  logic [31:0]  rf_rdata2;
  logic         out_valid;
  logic         out_ready;
  logic [143:0] out_bus;

  int total = 0;
  int bad   = 0;

  logic [31:0] rf [32];
  bit          m_vld;
  logic [31:0] m_pc;
  logic [31:0] m_inst;

  localparam int M_ADD = 0, M_SUB = 1, M_AND = 2, M_OR = 3, M_XOR = 4, M_ADDI = 5,
                 M_LD = 6, M_ST = 7, M_LU12I = 8, M_JIRL = 9, M_B = 10, M_BL = 11,
                 M_BEQ = 12, M_BNE = 13, M_ILL = 14;

  id_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bus    (in_bus),
    .flush     (flush),
    .rf_raddr1 (rf_raddr1),
    .rf_raddr2 (rf_raddr2),
    .rf_rdata1 (rf_rdata1),
    .rf_rdata2 (rf_rdata2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bus   (out_bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rdrf(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : rf[a];
  endfunction

  assign rf_rdata1 = rdrf(rf_raddr1);
  assign rf_rdata2 = rdrf(rf_raddr2);

  function automatic int mnem(input logic [31:0] i);
    case (i[31:15])
      17'h20: return M_ADD;
      17'h22: return M_SUB;
      17'h29: return M_AND;
      17'h2A: return M_OR;
      17'h2B: return M_XOR;
      default: ;
    endcase
    case (i[31:22])
      10'h00A: return M_ADDI;
      10'h0A2: return M_LD;
      10'h0A6: return M_ST;
      default: ;
    endcase
    if (i[31:25] == 7'h0A) return M_LU12I;
    case (i[31:26])
      6'h13: return M_JIRL;
      6'h14: return M_B;
      6'h15: return M_BL;
      6'h16: return M_BEQ;
      6'h17: return M_BNE;
      default: ;
    endcase
    return M_ILL;
  endfunction

  // Expected EXE bundle and read addresses from the instruction's architectural meaning.
  task automatic expect_bus(input logic [31:0] pc, input logic [31:0] i,
                            output logic [143:0] eb, output logic [4:0] a1, output logic [4:0] a2);
    int m;
    logic signed [11:0] s12;
    logic signed [15:0] o16;
    logic signed [25:0] o26;
    logic [31:0] imm;
    logic [4:0] rd;
    logic [3:0] alu;
    logic [2:0] br;
    logic we, re, mw, ill;
    m   = mnem(i);
    s12 = i[21:10];
    o16 = i[25:10];
    o26 = {i[9:0], i[25:10]};
    rd  = (m == M_BL) ? 5'd1 : i[4:0];
    a1  = (m == M_LU12I) ? 5'd0 : i[9:5];
    a2  = (m inside {M_ST, M_BEQ, M_BNE}) ? i[4:0] : i[14:10];
    we  = (m inside {M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_ADDI, M_LD, M_LU12I, M_JIRL, M_BL})
          && (rd != 5'd0);
    re  = (m == M_LD);
    mw  = (m == M_ST);
    ill = (m == M_ILL);
    case (m)
      M_SUB:   alu = 4'd1;
      M_AND:   alu = 4'd2;
      M_OR:    alu = 4'd3;
      M_XOR:   alu = 4'd4;
      M_LU12I: alu = 4'd5;
      default: alu = 4'd0;
    endcase
    case (m)
      M_B:     br = 3'd1;
      M_BL:    br = 3'd2;
      M_JIRL:  br = 3'd3;
      M_BEQ:   br = 3'd4;
      M_BNE:   br = 3'd5;
      default: br = 3'd0;
    endcase
    if (m inside {M_ADDI, M_LD, M_ST})          imm = 32'(int'(s12));
    else if (m inside {M_JIRL, M_BEQ, M_BNE})   imm = 32'(int'(o16) * 4);
    else if (m inside {M_B, M_BL})              imm = 32'(int'(o26) * 4);
    else if (m == M_LU12I)                      imm = i[24:5] << 12;
    else                                        imm = 32'd0;
    eb = {pc, rdrf(a1), rdrf(a2), imm, rd, alu, br, we, re, mw, ill};
  endtask

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [143:0] eb;
    logic [4:0] a1, a2;
    chk("out_valid", 144'(out_valid), 144'(m_vld));
    chk("in_ready", 144'(in_ready), 144'(!m_vld || out_ready));
    if (m_vld) begin
      expect_bus(m_pc, m_inst, eb, a1, a2);
      chk("out_bus", out_bus, eb);
      chk("raddr1", 144'(rf_raddr1), 144'(a1));
      chk("raddr2", 144'(rf_raddr2), 144'(a2));
    end
  endtask

  task automatic tick();
    bit fin, fout;
    fin  = in_valid && (!m_vld || out_ready);
    fout = m_vld && out_ready;
    @(posedge clk);
    if (flush) m_vld = 0;
    else if (fin) begin
      m_vld  = 1;
      m_pc   = in_bus[63:32];
      m_inst = in_bus[31:0];
    end else if (fout) m_vld = 0;
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 14))
      0:  return {17'h20, r[14:0]};
      1:  return {17'h22, r[14:0]};
      2:  return {17'h29, r[14:0]};
      3:  return {17'h2A, r[14:0]};
      4:  return {17'h2B, r[14:0]};
      5:  return {10'h00A, r[21:0]};
      6:  return {10'h0A2, r[21:0]};
      7:  return {10'h0A6, r[21:0]};
      8:  return {7'h0A, r[24:0]};
      9:  return {6'h13, r[25:0]};
      10: return {6'h14, r[25:0]};
      11: return {6'h15, r[25:0]};
      12: return {6'h16, r[25:0]};
      13: return {6'h17, r[25:0]};
      default: return r;
    endcase
  endfunction

  logic [143:0] snap;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_bus = '0; flush = 1'b0; out_ready = 1'b0;
    m_vld = 0; m_pc = 32'h1C00_0000; m_inst = '0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("reset_valid", 144'(out_valid), 144'(0));
    chk("reset_ready", 144'(in_ready), 144'(1));
    chk("reset_bus", out_bus, {32'h1C00_0000, 112'h0});

    // addi.w r1,r1,1
    in_valid = 1'b1; out_ready = 1'b1; in_bus = {32'h1C00_0000, 32'h0280_0421};
    tick();
    in_valid = 1'b0;
    #1;
    chk("t1_valid", 144'(out_valid), 144'(1));
    chk("t1_imm", 144'(out_bus[47:16]), 144'(1));
    chk("t1_rd", 144'(out_bus[15:11]), 144'(1));
    chk("t1_rf_we", 144'(out_bus[3]), 144'(1));
    chk("t1_alu", 144'(out_bus[10:7]), 144'(0));
    chk("t1_raddr1", 144'(rf_raddr1), 144'(1));
    check_all();
    tick();

    // Four back-to-back add.w
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; out_ready = 1'b1;
      in_bus = {32'h1C00_1000 + 32'(k * 4), 32'h0010_0000 | 32'(k << 10) | 32'((k + 1) << 5) | 32'(k + 2)};
      #1;
      chk("t2_in_ready", 144'(in_ready), 144'(1));
      tick();
      chk("t2_pc", 144'(out_bus[143:112]), 144'(32'h1C00_1000 + 32'(k * 4)));
      check_all();
    end
    in_valid = 1'b0;
    tick();

    // Stall: add.w r4,r3,r2 held while fetch keeps offering
    rf[3] = 32'h5;
    in_valid = 1'b1; out_ready = 1'b1; in_bus = {32'h1C00_2000, 32'h0010_0864};
    tick();
    out_ready = 1'b0; in_bus = {32'h1C00_2004, 32'h0010_0C85};
    #1;
    snap = out_bus;
    chk("t3_src1_5", 144'(out_bus[111:80]), 144'(32'h5));
    for (int k = 0; k < 5; k++) begin
      chk("t3_in_ready", 144'(in_ready), 144'(0));
      chk("t3_hold", out_bus, snap);
      tick();
    end
    rf[3] = 32'h9;
    #1;
    chk("t3_src1_9", 144'(out_bus[111:80]), 144'(32'h9));
    check_all();
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("t3_fire_once", 144'(out_valid), 144'(0));
    check_all();

    // Flush with a same-cycle accept
    in_valid = 1'b1; out_ready = 1'b1; in_bus = {32'h1C00_3000, 32'h0010_0421};
    tick();
    in_bus = {32'hDEAD_0000, 32'h0290_0842}; flush = 1'b1;
    #1;
    check_all();
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("t4_flushed", 144'(out_valid), 144'(0));
    tick();
    chk("t4_never", 144'(out_valid), 144'(0));

    // Illegal encoding and bl with offs26 = -4
    in_valid = 1'b1; in_bus = {32'h1C00_4000, 32'hFFFF_FFFF};
    tick();
    chk("t5_ill_flags", 144'(out_bus[3:0]), 144'(4'b0001));
    check_all();
    in_bus = {32'h1C00_4004, 32'h57FF_F3FF};
    tick();
    chk("t5_bl_imm", 144'(out_bus[47:16]), 144'(32'hFFFF_FFF0));
    chk("t5_bl_rd", 144'(out_bus[15:11]), 144'(1));
    check_all();
    in_valid = 1'b0;
    tick();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_bus    = {$urandom & 32'hFFFF_FFFC, rand_inst()};
      if ($urandom_range(0, 3) == 0) rf[$urandom_range(1, 31)] = $urandom;
      #1;
      check_all();
      tick();
    end
    flush = 1'b0;

    // Async reset while a bundle is stalled
    in_valid = 1'b1; out_ready = 1'b0; in_bus = {32'h1C00_5000, 32'h0280_0421};
    tick();
    in_valid = 1'b0;
    tick();
    chk("t6_held", 144'(out_valid), 144'(1));
    #2 reset = 1'b1;
    #1;
    m_vld = 0;
    chk("t6_valid_drop", 144'(out_valid), 144'(0));
    chk("t6_pc", 144'(out_bus[143:112]), 144'(32'h1C00_0000));
    chk("t6_in_ready", 144'(in_ready), 144'(1));
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("t6_no_fire", 144'(out_valid), 144'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
